pipe_wr_arbiter: RTL and testbench
==================================

Name: pipe_wr_arbiter

Overview:
Arbiter and scheduler for one pipe register stage that has two write ports (wr_en0/indata0, wr_en1/indata1).
- Shares the stage between two requesters using round-robin with a bounded burst length.
- Issues a write only when the stage can accept it, so no beat is ever dropped when the stage holds data and the lower level is not empty.
- Sits directly upstream of the stage; the stage's sum_empty output feeds back as stage_ready.

Parameters:
DSIZE, 8, data width of each requester and of each write port.
MAX_BURST, 4, maximum consecutive beats granted to one owner while the other requester is waiting; legal range 1..255.
CW, 8, width of the burst counter; must satisfy 2^CW > MAX_BURST.

Ports:
clock  in  1  system clock, rising edge.
rst  in  1  synchronous reset, active-high.
req0  in  1  requester 0 has a beat; it must hold req0 and data0 stable until ack0.
data0  in  DSIZE  requester 0 beat.
ack0  out  1  beat 0 transferred this cycle.
req1  in  1  requester 1 has a beat; same holding rule as req0.
data1  in  DSIZE  requester 1 beat.
ack1  out  1  beat 1 transferred this cycle.
stage_ready  in  1  stage can accept a write (stage sum_empty).
wr_en0  out  1  write port 0 enable to the stage.
indata0  out  DSIZE  write port 0 data.
wr_en1  out  1  write port 1 enable to the stage.
indata1  out  DSIZE  write port 1 data.
owner  out  2  current owner: 00 idle, 01 port0, 10 port1.
burst_cnt  out  CW  beats granted to the current owner in the current burst.

Behaviour:
- FSM states (registered): IDLE, OWN0, OWN1. Reset values: state=IDLE, burst_cnt=0, last_grant=1 (so port0 wins the first tie).
- Grant logic is combinational from state, the reqs and stage_ready. Latency is zero: a beat transfers in the cycle where ackN=1.
- Invariants:
  - ackN = wr_enN.
  - indataN = dataN when wr_enN=1, else all zeros.
  - At most one of wr_en0/wr_en1 is high in any cycle.
  - No write is issued when stage_ready=0.
- IDLE:
  - Only one req high → grant it.
  - Both high → grant the port opposite last_grant.
  - On a grant: move to OWNx with burst_cnt=1.
  - No req → stay IDLE.
- OWNx:
  - Owner req=1, stage_ready=1, and (burst_cnt<MAX_BURST or other req=0) → grant owner. burst_cnt increments, saturating at MAX_BURST.
  - Owner req=1, burst_cnt==MAX_BURST, other req=1, stage_ready=1 → grant the other port. Move to OWN(other), burst_cnt=1, last_grant=other.
  - Owner req=0 and other req=1 → same-cycle handover: grant the other port if stage_ready=1, move to OWN(other), burst_cnt=1.
  - Owner req=0 and other req=0 → return to IDLE, burst_cnt=0.
  - stage_ready=0 → no grant; state and burst_cnt hold. A stall does not count toward the burst.
- last_grant updates on every granted beat.
- owner output: 00 in IDLE, 01 in OWN0, 10 in OWN1. All outputs are 0 during reset.
- Reset asserted mid-burst: the next cycle is IDLE, no write is issued, and counters clear.
- MAX_BURST=1 degenerates to strict alternation whenever both ports request.

Optional Feature:
PIPE_WR_ARB_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0, grant_cnt1 and stall_cnt, each 16 bits, clearing on rst.
  - grant_cnt0/grant_cnt1 increment per granted beat on that port.
  - stall_cnt increments each cycle with (req0|req1) & !stage_ready.
  - All three wrap at 16'hFFFF→0.
- Undefined: these ports and registers do not exist, and arbitration behaviour is identical.

Decomposition:
- Shared include pipe_arb_defs.vh: state encodings ST_IDLE=2'd0, ST_OWN0=2'd1, ST_OWN1=2'd2; owner encodings; stats width 16.
- One sub-module, pipe_arb_burst_cnt: saturating CW-bit counter with load-1, increment, clear and a "at MAX_BURST" flag output.

Test Plan:
1. Single requester: req0=1 held with data0=8'hA5, stage_ready=1 for 6 cycles → wr_en0=1 every cycle, indata0=8'hA5, owner=01, burst_cnt saturates at 4; wr_en1 stays 0.
2. Both requesting continuously, stage_ready=1, MAX_BURST=4 → grant pattern 0,0,0,0,1,1,1,1,0...; never both write enables high.
3. Backpressure: both requesting, stage_ready toggles 1,0,0,1 → no write in the 0 cycles, burst_cnt unchanged during them, data0 not acknowledged until transferred.
4. Handover: owner is port0 with burst_cnt=2, req0 drops, req1=1 the same cycle → ack1 that cycle, owner=10, burst_cnt=1.
5. Reset mid-burst: OWN1 with burst_cnt=3, rst=1 for one cycle → owner=00, burst_cnt=0, no write; afterwards a both-request tie grants port0 first.
6. With PIPE_WR_ARB_STATS_EN: 10 beats on port1 and 3 stall cycles → grant_cnt1=10, grant_cnt0=0, stall_cnt=3.

Source files
------------

// File: rtl/pipe_wr_arbiter_pkg.sv
// Shared types and encodings for the two-port pipe-stage write arbiter.
package pipe_wr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    localparam logic [1:0] OWNER_IDLE = 2'b00;
    localparam logic [1:0] OWNER_P0   = 2'b01;
    localparam logic [1:0] OWNER_P1   = 2'b10;

    localparam int STATS_W = 16;

    function automatic logic [1:0] owner_code(input state_t s);
        case (s)
            ST_OWN0: owner_code = OWNER_P0;
            ST_OWN1: owner_code = OWNER_P1;
            default: owner_code = OWNER_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/pipe_arb_burst_cnt.sv
// Saturating burst-length counter: clear, load-to-1, increment up to MAX_BURST.
// Registered count; at_max decodes the current count.
module pipe_arb_burst_cnt #(
    parameter int CW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          clr,
    input  logic          load1,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          at_max
);

    localparam logic [CW-1:0] MAX_V = CW'(MAX_BURST);

    assign at_max = (cnt == MAX_V);

    always_ff @(posedge clock) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= CW'(1);
        end else if (inc && !at_max) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/pipe_wr_arbiter.sv
// Round-robin, burst-bounded arbiter feeding the two write ports of one pipe stage.
// Zero latency (beat moves in the ack cycle); no write while stage_ready=0, requesters hold until ack.
// Optional counters under PIPE_WR_ARB_STATS_EN.
module pipe_wr_arbiter
    import pipe_wr_arbiter_pkg::*;
#(
    parameter int DSIZE     = 8,
    parameter int MAX_BURST = 4,
    parameter int CW        = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             req0,
    input  logic [DSIZE-1:0] data0,
    output logic             ack0,
    input  logic             req1,
    input  logic [DSIZE-1:0] data1,
    output logic             ack1,
    input  logic             stage_ready,
    output logic             wr_en0,
    output logic [DSIZE-1:0] indata0,
    output logic             wr_en1,
    output logic [DSIZE-1:0] indata1,
    output logic [1:0]       owner,
    output logic [CW-1:0]    burst_cnt
`ifdef PIPE_WR_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0] grant_cnt0,
    output logic [STATS_W-1:0] grant_cnt1,
    output logic [STATS_W-1:0] stall_cnt
`endif
);

    state_t         state;
    state_t         state_next;
    logic           last_grant;   // 0: port0 got the latest beat, 1: port1
    logic           gnt0;
    logic           gnt1;
    logic           cnt_clr;
    logic           cnt_load1;
    logic           cnt_inc;
    logic           cnt_at_max;
    logic [CW-1:0]  cnt;

    pipe_arb_burst_cnt #(
        .CW        (CW),
        .MAX_BURST (MAX_BURST)
    ) u_burst_cnt (
        .clock  (clock),
        .rst    (rst),
        .clr    (cnt_clr),
        .load1  (cnt_load1),
        .inc    (cnt_inc),
        .cnt    (cnt),
        .at_max (cnt_at_max)
    );

    always_comb begin
        state_next = state;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        cnt_clr    = 1'b0;
        cnt_load1  = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (stage_ready) begin
                    if (req0 && (!req1 || last_grant)) begin
                        gnt0       = 1'b1;
                        cnt_load1  = 1'b1;
                        state_next = ST_OWN0;
                    end else if (req1) begin
                        gnt1       = 1'b1;
                        cnt_load1  = 1'b1;
                        state_next = ST_OWN1;
                    end
                end
            end
            ST_OWN0: begin
                if (!req0 && !req1) begin
                    cnt_clr    = 1'b1;
                    state_next = ST_IDLE;
                end else if (stage_ready) begin
                    // Owner keeps the stage until its burst is spent and port1 is waiting.
                    if (req0 && (!cnt_at_max || !req1)) begin
                        gnt0    = 1'b1;
                        cnt_inc = 1'b1;
                    end else begin
                        gnt1       = 1'b1;
                        cnt_load1  = 1'b1;
                        state_next = ST_OWN1;
                    end
                end
            end
            ST_OWN1: begin
                if (!req0 && !req1) begin
                    cnt_clr    = 1'b1;
                    state_next = ST_IDLE;
                end else if (stage_ready) begin
                    if (req1 && (!cnt_at_max || !req0)) begin
                        gnt1    = 1'b1;
                        cnt_inc = 1'b1;
                    end else begin
                        gnt0       = 1'b1;
                        cnt_load1  = 1'b1;
                        state_next = ST_OWN0;
                    end
                end
            end
            default: begin
                cnt_clr    = 1'b1;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
        end else begin
            state <= state_next;
            if (gnt0) begin
                last_grant <= 1'b0;
            end else if (gnt1) begin
                last_grant <= 1'b1;
            end
        end
    end

    // Reset is synchronous, so gate everything visible while it is asserted.
    assign wr_en0    = gnt0 & ~rst;
    assign wr_en1    = gnt1 & ~rst;
    assign ack0      = wr_en0;
    assign ack1      = wr_en1;
    assign indata0   = wr_en0 ? data0 : '0;
    assign indata1   = wr_en1 ? data1 : '0;
    assign owner     = rst ? OWNER_IDLE : owner_code(state);
    assign burst_cnt = rst ? '0 : cnt;

`ifdef PIPE_WR_ARB_STATS_EN
    logic [STATS_W-1:0] grant_q0;
    logic [STATS_W-1:0] grant_q1;
    logic [STATS_W-1:0] stall_q;

    always_ff @(posedge clock) begin
        if (rst) begin
            grant_q0 <= '0;
            grant_q1 <= '0;
            stall_q  <= '0;
        end else begin
            if (wr_en0) begin
                grant_q0 <= grant_q0 + STATS_W'(1);
            end
            if (wr_en1) begin
                grant_q1 <= grant_q1 + STATS_W'(1);
            end
            if ((req0 | req1) & ~stage_ready) begin
                stall_q <= stall_q + STATS_W'(1);
            end
        end
    end

    assign grant_cnt0 = rst ? '0 : grant_q0;
    assign grant_cnt1 = rst ? '0 : grant_q1;
    assign stall_cnt  = rst ? '0 : stall_q;
`endif

endmodule

// File: tb/tb_pipe_wr_arbiter.sv
// Scoreboarded bench for pipe_wr_arbiter: per-cycle grant/owner/count tables plus data ordering.
module tb_pipe_wr_arbiter;

    logic       clock = 1'b0;
    logic       rst;
    logic       req0, req1, stage_ready;
    logic [7:0] data0, data1;
    logic       ack0, ack1, wr_en0, wr_en1;
    logic [7:0] indata0, indata1;
    logic [1:0] owner;
    logic [7:0] burst_cnt;
`ifdef PIPE_WR_ARB_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1, stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] src0[$];
    logic [7:0] src1[$];
    logic [7:0] sb0[$];
    logic [7:0] sb1[$];

    always #5 clock = ~clock;

    pipe_wr_arbiter #(.DSIZE(8), .MAX_BURST(4), .CW(8)) dut (
        .clock       (clock),
        .rst         (rst),
        .req0        (req0),
        .data0       (data0),
        .ack0        (ack0),
        .req1        (req1),
        .data1       (data1),
        .ack1        (ack1),
        .stage_ready (stage_ready),
        .wr_en0      (wr_en0),
        .indata0     (indata0),
        .wr_en1      (wr_en1),
        .indata1     (indata1),
        .owner       (owner),
        .burst_cnt   (burst_cnt)
`ifdef PIPE_WR_ARB_STATS_EN
        ,
        .grant_cnt0  (grant_cnt0),
        .grant_cnt1  (grant_cnt1),
        .stall_cnt   (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push0(input logic [7:0] v);
        src0.push_back(v);
        sb0.push_back(v);
    endtask

    task automatic push1(input logic [7:0] v);
        src1.push_back(v);
        sb1.push_back(v);
    endtask

    // One cycle: drive inputs, check at negedge, retire acknowledged beats.
    // g / own: 0 none, 1 port0, 2 port1; own and cnt are the values seen during this cycle.
    task automatic step(input string tag, input logic sr, input logic [1:0] g,
                        input logic [1:0] own, input int cnt);
        logic [8:0] exp;
        stage_ready = sr;
        req0  = (src0.size() > 0);
        data0 = req0 ? src0[0] : 8'h00;
        req1  = (src1.size() > 0);
        data1 = req1 ? src1[0] : 8'h00;
        @(negedge clock);
        check({tag, ".wr"},  {30'd0, wr_en1, wr_en0}, {30'd0, g});
        check({tag, ".ack"}, {30'd0, ack1, ack0},     {30'd0, g});
        check({tag, ".own"}, {30'd0, owner},          {30'd0, own});
        check({tag, ".cnt"}, {24'd0, burst_cnt},      cnt);
        if (wr_en0) begin
            exp = (sb0.size() > 0) ? {1'b0, sb0.pop_front()} : 9'h100;
            check({tag, ".d0"}, {23'd0, 1'b0, indata0}, {23'd0, exp});
            if (src0.size() > 0) void'(src0.pop_front());
        end else begin
            check({tag, ".z0"}, {24'd0, indata0}, 32'd0);
        end
        if (wr_en1) begin
            exp = (sb1.size() > 0) ? {1'b0, sb1.pop_front()} : 9'h100;
            check({tag, ".d1"}, {23'd0, 1'b0, indata1}, {23'd0, exp});
            if (src1.size() > 0) void'(src1.pop_front());
        end else begin
            check({tag, ".z1"}, {24'd0, indata1}, 32'd0);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [1:0] gk;
        logic [1:0] gprev;

        // Reset with both requesting: every output must read zero.
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; stage_ready = 1'b1;
        data0 = 8'h5A; data1 = 8'hC3;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst.wr",  {30'd0, wr_en1, wr_en0}, 32'd0);
        check("rst.ack", {30'd0, ack1, ack0},     32'd0);
        check("rst.own", {30'd0, owner},          32'd0);
        check("rst.cnt", {24'd0, burst_cnt},      32'd0);
        check("rst.dat", {16'd0, indata1, indata0}, 32'd0);
        @(posedge clock);
        #1;
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;

        // Single requester, burst counter saturates at 4.
        for (int i = 0; i < 6; i++) push0(8'hA5);
        step("single", 1'b1, 2'd1, 2'd0, 0);
        step("single", 1'b1, 2'd1, 2'd1, 1);
        step("single", 1'b1, 2'd1, 2'd1, 2);
        step("single", 1'b1, 2'd1, 2'd1, 3);
        step("single", 1'b1, 2'd1, 2'd1, 4);
        step("single", 1'b1, 2'd1, 2'd1, 4);
        step("single", 1'b1, 2'd0, 2'd1, 4);
        step("single", 1'b1, 2'd0, 2'd0, 0);

        // Both requesting: bursts of four alternate; port0 went last so port1 wins the tie.
        for (int i = 0; i < 8; i++) begin
            push0(8'h10 + 8'(i));
            push1(8'h20 + 8'(i));
        end
        gprev = 2'd0;
        for (int k = 0; k < 16; k++) begin
            gk = (((k / 4) % 2) == 0) ? 2'd2 : 2'd1;
            step("rr", 1'b1, gk, gprev, (k == 0) ? 0 : ((k - 1) % 4) + 1);
            gprev = gk;
        end
        step("rr", 1'b1, 2'd0, 2'd1, 4);
        step("rr", 1'b1, 2'd0, 2'd0, 0);

        // Backpressure: stalls freeze state and count, data held until transferred.
        for (int i = 0; i < 3; i++) begin
            push0(8'h30 + 8'(i));
            push1(8'h40 + 8'(i));
        end
        step("bp", 1'b1, 2'd2, 2'd0, 0);
        step("bp", 1'b0, 2'd0, 2'd2, 1);
        step("bp", 1'b0, 2'd0, 2'd2, 1);
        step("bp", 1'b1, 2'd2, 2'd2, 1);
        step("bp", 1'b1, 2'd2, 2'd2, 2);
        step("bp", 1'b1, 2'd1, 2'd2, 3);
        step("bp", 1'b0, 2'd0, 2'd1, 1);
        step("bp", 1'b1, 2'd1, 2'd1, 1);
        step("bp", 1'b1, 2'd1, 2'd1, 2);
        step("bp", 1'b1, 2'd0, 2'd1, 3);
        step("bp", 1'b1, 2'd0, 2'd0, 0);

        // Handover: port0 at count 2 drops, port1 granted in the same cycle.
        push0(8'h50);
        push0(8'h51);
        step("ho", 1'b1, 2'd1, 2'd0, 0);
        step("ho", 1'b1, 2'd1, 2'd1, 1);
        push1(8'h60);
        step("ho", 1'b1, 2'd2, 2'd1, 2);
        step("ho", 1'b1, 2'd0, 2'd2, 1);
        step("ho", 1'b1, 2'd0, 2'd0, 0);

        // Reset mid-burst in OWN1 at count 3, then a tie goes to port0.
        for (int i = 0; i < 6; i++) push1(8'h80 + 8'(i));
        step("mid", 1'b1, 2'd2, 2'd0, 0);
        step("mid", 1'b1, 2'd2, 2'd2, 1);
        step("mid", 1'b1, 2'd2, 2'd2, 2);
        rst = 1'b1;
        step("mid.rst", 1'b1, 2'd0, 2'd0, 0);
        rst = 1'b0;
        push0(8'h70);
        step("tie", 1'b1, 2'd1, 2'd0, 0);
        step("tie", 1'b1, 2'd2, 2'd1, 1);
        step("tie", 1'b1, 2'd2, 2'd2, 1);
        step("tie", 1'b1, 2'd2, 2'd2, 2);
        step("tie", 1'b1, 2'd0, 2'd2, 3);
        step("tie", 1'b1, 2'd0, 2'd0, 0);

        // Ten beats on port1 with three stall cycles, counters cleared first.
        rst = 1'b1;
        step("st.rst", 1'b1, 2'd0, 2'd0, 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) push1(8'h90 + 8'(i));
        step("st", 1'b1, 2'd2, 2'd0, 0);
        step("st", 1'b0, 2'd0, 2'd2, 1);
        step("st", 1'b0, 2'd0, 2'd2, 1);
        step("st", 1'b0, 2'd0, 2'd2, 1);
        step("st", 1'b1, 2'd2, 2'd2, 1);
        step("st", 1'b1, 2'd2, 2'd2, 2);
        step("st", 1'b1, 2'd2, 2'd2, 3);
        for (int i = 0; i < 6; i++) step("st", 1'b1, 2'd2, 2'd2, 4);
        step("st", 1'b1, 2'd0, 2'd2, 4);
`ifdef PIPE_WR_ARB_STATS_EN
        @(negedge clock);
        check("stats.g0", {16'd0, grant_cnt0}, 32'd0);
        check("stats.g1", {16'd0, grant_cnt1}, 32'd10);
        check("stats.st", {16'd0, stall_cnt},  32'd3);
`endif

        check("sb.left", sb0.size() + sb1.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
